// File: rtl/pulse_catch_multi.sv
// pulse_catch_multi: multi-channel pulse catcher.
// Each channel synchronizes an asynchronous feedback input, qualifies pulses
// (input away from its idle level) that last at least N = max(io_filterCnt, 1)
// clocks, and reports a sticky catch flag, a one-cycle catch strobe, the width
// of the last completed qualified pulse and a sticky width-overflow flag.
// Channels share only the clock, reset and the filter count.
module pulse_catch_multi #(
  parameter int _RAM_WIDTH  = 32,
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                         io_clk,
  input  logic                         io_rst_n,
  input  logic [CH_NUM-1:0]            io_fb_in,
  input  logic [CH_NUM-1:0]            io_defaultLevel,
  input  logic [CH_NUM-1:0]            io_enable,
  input  logic [_RAM_WIDTH-1:0]        io_filterCnt,
  input  logic [CH_NUM-1:0]            io_clear,
  output logic [CH_NUM-1:0]            io_fb_catch,
  output logic [CH_NUM-1:0]            io_catch_pulse,
  output logic [CH_NUM*_RAM_WIDTH-1:0] io_width,
  output logic [CH_NUM-1:0]            io_width_valid,
  output logic [CH_NUM-1:0]            io_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [_RAM_WIDTH-1:0] CNT_ONE = _RAM_WIDTH'(1);
  localparam logic [_RAM_WIDTH-1:0] CNT_MAX = '1;

  // A filter count of zero behaves like one: a single active sample qualifies.
  logic [_RAM_WIDTH-1:0] n_eff;
  assign n_eff = (io_filterCnt == '0) ? CNT_ONE : io_filterCnt;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   active;

    state_t                 state_reg,  state_next;
    logic [_RAM_WIDTH-1:0]  cnt_reg,    cnt_next;
    logic [_RAM_WIDTH-1:0]  cnt_inc;
    logic [_RAM_WIDTH-1:0]  width_reg,  width_next;
    logic                   catch_reg,  catch_next;
    logic                   pulse_reg,  pulse_next;
    logic                   wv_reg,     wv_next;
    logic                   ovf_reg,    ovf_next;
    logic                   set_ovf;

    // Input synchronizer; always clears to 0, independent of the idle level.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], io_fb_in[gi]};
      end
    end

    // Idle level is applied live, so changing it mid-pulse looks like an edge.
    assign active = sync_reg[SYNC_STAGES-1] ^ io_defaultLevel[gi];

    // Saturating increment of the pulse-length counter.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;

    // Next-state, counter and output-strobe logic for one channel.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      width_next = width_reg;
      pulse_next = 1'b0;
      wv_next    = 1'b0;
      set_ovf    = 1'b0;

      if (!io_enable[gi]) begin
        // Disabled: abandon any pulse in progress, keep flags and width.
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            if (active) begin
              cnt_next = CNT_ONE;
              if (n_eff == CNT_ONE) begin
                state_next = ST_ACTIVE;
                pulse_next = 1'b1;
              end else begin
                state_next = ST_QUAL;
              end
            end else begin
              cnt_next = '0;
            end
          end

          ST_QUAL: begin
            if (active) begin
              cnt_next = cnt_inc;
              // Live compare: a filter count lowered mid-pulse takes effect now.
              if (cnt_inc >= n_eff) begin
                state_next = ST_ACTIVE;
                pulse_next = 1'b1;
              end
            end else begin
              // Too short: glitch is dropped without any report.
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          end

          ST_ACTIVE: begin
            if (active) begin
              cnt_next = cnt_inc;
            end else begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              width_next = cnt_reg;
              wv_next    = 1'b1;
            end
          end

          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        endcase

        // A qualified pulse whose length has hit the counter ceiling.
        set_ovf = (state_next == ST_ACTIVE) && (cnt_next == CNT_MAX);
      end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    assign catch_next = pulse_next | (catch_reg & ~io_clear[gi]);
    assign ovf_next   = set_ovf    | (ovf_reg   & ~io_clear[gi]);

    // State, counter and registered outputs of the channel.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        width_reg <= '0;
        catch_reg <= 1'b0;
        pulse_reg <= 1'b0;
        wv_reg    <= 1'b0;
        ovf_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        width_reg <= width_next;
        catch_reg <= catch_next;
        pulse_reg <= pulse_next;
        wv_reg    <= wv_next;
        ovf_reg   <= ovf_next;
      end
    end

    assign io_fb_catch[gi]                          = catch_reg;
    assign io_catch_pulse[gi]                       = pulse_reg;
    assign io_width[gi*_RAM_WIDTH +: _RAM_WIDTH]    = width_reg;
    assign io_width_valid[gi]                       = wv_reg;
    assign io_overflow[gi]                          = ovf_reg;

  end : g_ch

endmodule

// File: tb/tb_pulse_catch_multi.sv
// Testbench for pulse_catch_multi: directed scenarios with fixed expectations
// plus a randomized run checked against a run-length reference model.
module tb_pulse_catch_multi;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int S  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   fb_in, def_lvl, en, clr;
  logic [W-1:0]    filt;
  logic [CH-1:0]   fb_catch, catch_pulse, wv, ovf;
  logic [CH*W-1:0] width;

  // Narrow instance for counter saturation.
  logic            fb4, def4, en4, clr4;
  logic [3:0]      filt4;
  logic            catch4, pulse4, wv4, ovf4;
  logic [3:0]      width4;

  int n_pass  = 0;
  int n_total = 0;
  int cnt;

  always #5 clk = ~clk;

  pulse_catch_multi #(._RAM_WIDTH(W), .CH_NUM(CH), .SYNC_STAGES(S)) dut (
    .io_clk(clk), .io_rst_n(rst_n), .io_fb_in(fb_in), .io_defaultLevel(def_lvl),
    .io_enable(en), .io_filterCnt(filt), .io_clear(clr), .io_fb_catch(fb_catch),
    .io_catch_pulse(catch_pulse), .io_width(width), .io_width_valid(wv),
    .io_overflow(ovf));

  pulse_catch_multi #(._RAM_WIDTH(4), .CH_NUM(1), .SYNC_STAGES(S)) dut4 (
    .io_clk(clk), .io_rst_n(rst_n), .io_fb_in(fb4), .io_defaultLevel(def4),
    .io_enable(en4), .io_filterCnt(filt4), .io_clear(clr4), .io_fb_catch(catch4),
    .io_catch_pulse(pulse4), .io_width(width4), .io_width_valid(wv4),
    .io_overflow(ovf4));

  // Reference model: per channel, the length of the current run of active
  // enabled samples and whether that run has already qualified.
  bit [S-1:0]  m_pipe   [CH];
  int unsigned m_run    [CH];
  bit          m_caught [CH];
  bit          m_catch  [CH];
  bit          m_pulse  [CH];
  bit          m_wv     [CH];
  bit          m_ovf    [CH];
  bit [W-1:0]  m_width  [CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pipe[c] = '0; m_run[c] = 0; m_caught[c] = 0; m_catch[c] = 0;
      m_pulse[c] = 0; m_wv[c] = 0; m_ovf[c] = 0; m_width[c] = '0;
    end
  endfunction

  function automatic void model_step();
    int unsigned n;
    bit a, so;
    n = (filt == 0) ? 1 : filt;
    for (int c = 0; c < CH; c++) begin
      a = m_pipe[c][S-1] ^ def_lvl[c];
      so = 0;
      m_pulse[c] = 0;
      m_wv[c] = 0;
      if (!en[c]) begin
        m_run[c] = 0; m_caught[c] = 0;
      end else if (a) begin
        if (m_run[c] != 32'hFFFF_FFFF) m_run[c] = m_run[c] + 1;
        if (!m_caught[c] && m_run[c] >= n) begin
          m_caught[c] = 1; m_pulse[c] = 1;
        end
        so = m_caught[c] && (m_run[c] == 32'hFFFF_FFFF);
      end else begin
        if (m_caught[c]) begin
          m_width[c] = m_run[c]; m_wv[c] = 1;
        end
        m_run[c] = 0; m_caught[c] = 0;
      end
      m_catch[c] = m_pulse[c] | (m_catch[c] & !clr[c]);
      m_ovf[c]   = so | (m_ovf[c] & !clr[c]);
      m_pipe[c]  = {m_pipe[c][S-2:0], fb_in[c]};
    end
  endfunction

  // Advance one clock; leaves time just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fb_in = '0; def_lvl = '0; en = '1; clr = '0; filt = 10;
    fb4 = 0; def4 = 0; en4 = 0; clr4 = 0; filt4 = 3;
    do_reset();
    n_total++;
    if ({fb_catch, catch_pulse, wv, ovf} !== '0) $display("FAIL reset_flags: got %h want 0", {fb_catch, catch_pulse, wv, ovf});
    else n_pass++;
    n_total++;
    if (width !== '0) $display("FAIL reset_width: got %h want 0", width);
    else n_pass++;
    n_total++;
    if ({catch4, pulse4, wv4, ovf4, width4} !== '0) $display("FAIL reset_narrow: got %h want 0", {catch4, pulse4, wv4, ovf4, width4});
    else n_pass++;
  endtask

  // filterCnt=10, ch0 high 10 clocks: qualifies exactly at the last sample.
  task automatic test_qualify();
    filt = 10;
    fb_in[0] = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      if (catch_pulse[0]) cnt++;
      n_total++;
      if (catch_pulse[0] !== (k == 12)) $display("FAIL qual_pulse k=%0d: got %b want %b", k, catch_pulse[0], (k == 12));
      else n_pass++;
      n_total++;
      if (wv[0] !== (k == 13)) $display("FAIL qual_wv k=%0d: got %b want %b", k, wv[0], (k == 13));
      else n_pass++;
      if (k == 13) begin
        n_total++;
        if (width[31:0] !== 32'd10) $display("FAIL qual_width: got %0d want 10", width[31:0]);
        else n_pass++;
      end
      if (k == 10) fb_in[0] = 1'b0;
    end
    n_total++;
    if (fb_catch[0] !== 1'b1 || cnt != 1) $display("FAIL qual_sticky: got catch=%b pulses=%0d want 1/1", fb_catch[0], cnt);
    else n_pass++;
  endtask

  // filterCnt=10, ch1 high only 9 clocks: rejected silently.
  task automatic test_glitch();
    filt = 10;
    fb_in[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      n_total++;
      if (catch_pulse[1] !== 1'b0 || wv[1] !== 1'b0) $display("FAIL glitch_strobe k=%0d: got pulse=%b wv=%b want 0/0", k, catch_pulse[1], wv[1]);
      else n_pass++;
      if (k == 9) fb_in[1] = 1'b0;
    end
    n_total++;
    if (fb_catch[1] !== 1'b0) $display("FAIL glitch_flag: got %b want 0", fb_catch[1]);
    else n_pass++;
  endtask

  // Idle-high ch2, low pulse of 25 clocks, filterCnt=0, then clear.
  task automatic test_inverted();
    en[2] = 1'b0; fb_in[2] = 1'b1; def_lvl[2] = 1'b1; filt = 0;
    repeat (4) cycle();
    en[2] = 1'b1;
    repeat (3) cycle();
    n_total++;
    if (fb_catch[2] !== 1'b0) $display("FAIL inv_idle: got %b want 0", fb_catch[2]);
    else n_pass++;
    fb_in[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      n_total++;
      if (catch_pulse[2] !== (k == 3)) $display("FAIL inv_pulse k=%0d: got %b want %b", k, catch_pulse[2], (k == 3));
      else n_pass++;
      n_total++;
      if (wv[2] !== (k == 28)) $display("FAIL inv_wv k=%0d: got %b want %b", k, wv[2], (k == 28));
      else n_pass++;
      if (k == 28) begin
        n_total++;
        if (width[95:64] !== 32'd25) $display("FAIL inv_width: got %0d want 25", width[95:64]);
        else n_pass++;
      end
      if (k == 25) fb_in[2] = 1'b1;
    end
    n_total++;
    if (fb_catch[2] !== 1'b1) $display("FAIL inv_catch: got %b want 1", fb_catch[2]);
    else n_pass++;
    clr[2] = 1'b1;
    cycle();
    clr[2] = 1'b0;
    n_total++;
    if (fb_catch[2] !== 1'b0) $display("FAIL inv_clear: got %b want 0", fb_catch[2]);
    else n_pass++;
  endtask

  // 4-bit counter: 40-clock pulse saturates at 15; then set beats clear.
  task automatic test_overflow();
    en4 = 1; def4 = 0; filt4 = 3; clr4 = 0;
    fb4 = 1;
    for (int k = 1; k <= 46; k++) begin
      cycle();
      n_total++;
      if (ovf4 !== (k >= 17)) $display("FAIL ovf_flag k=%0d: got %b want %b", k, ovf4, (k >= 17));
      else n_pass++;
      if (k == 43) begin
        n_total++;
        if (wv4 !== 1'b1 || width4 !== 4'd15) $display("FAIL ovf_width: got wv=%b w=%0d want 1/15", wv4, width4);
        else n_pass++;
      end
      if (k == 40) fb4 = 0;
    end
    fb4 = 1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 5) begin
        n_total++;
        if (pulse4 !== 1'b1 || catch4 !== 1'b1 || ovf4 !== 1'b0) $display("FAIL ovf_setclear: got p=%b c=%b o=%b want 1/1/0", pulse4, catch4, ovf4);
        else n_pass++;
      end
      clr4 = (k == 4);
      if (k == 6) fb4 = 0;
    end
    en4 = 0;
  endtask

  // Reset while ch3 is ACTIVE discards it; re-qualifies after release.
  task automatic test_reset_mid();
    filt = 10;
    fb_in[3] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      if (k == 12) begin
        n_total++;
        if (catch_pulse[3] !== 1'b1) $display("FAIL rmid_first: got %b want 1", catch_pulse[3]);
        else n_pass++;
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({fb_catch, catch_pulse, wv, ovf} !== '0 || width !== '0) $display("FAIL rmid_async: got %h/%h want 0", {fb_catch, catch_pulse, wv, ovf}, width);
    else n_pass++;
    repeat (5) cycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cycle();
      n_total++;
      if (catch_pulse[3] !== (k == 12)) $display("FAIL rmid_recatch k=%0d: got %b want %b", k, catch_pulse[3], (k == 12));
      else n_pass++;
    end
    fb_in[3] = 1'b0;
    repeat (4) cycle();
  endtask

  // ch0 disabled mid-qualification while ch1 qualifies normally.
  task automatic test_enable_drop();
    filt = 10;
    clr = '1;
    cycle();
    clr = '0;
    fb_in[1:0] = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      n_total++;
      if (catch_pulse[0] !== 1'b0 || wv[0] !== 1'b0) $display("FAIL endrop_ch0 k=%0d: got p=%b wv=%b want 0/0", k, catch_pulse[0], wv[0]);
      else n_pass++;
      n_total++;
      if (catch_pulse[1] !== (k == 12)) $display("FAIL endrop_ch1 k=%0d: got %b want %b", k, catch_pulse[1], (k == 12));
      else n_pass++;
      if (k == 5) en[0] = 1'b0;
    end
    n_total++;
    if (fb_catch[1:0] !== 2'b10) $display("FAIL endrop_flags: got %b want 10", fb_catch[1:0]);
    else n_pass++;
    fb_in[1:0] = 2'b00;
    repeat (4) cycle();
    en[0] = 1'b1;
  endtask

  // Random traffic on all channels compared every cycle with the model.
  task automatic test_random();
    def_lvl = CH'($urandom);
    fb_in = def_lvl; en = '1; clr = '0; filt = 3;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5) == 0)  fb_in[c]   = ~fb_in[c];
        if ($urandom_range(39) == 0) en[c]      = ~en[c];
        if ($urandom_range(99) == 0) def_lvl[c] = ~def_lvl[c];
        clr[c] = ($urandom_range(19) == 0);
      end
      if (k % 200 == 0) filt = W'($urandom_range(7));
      cycle();
      for (int c = 0; c < CH; c++) begin
        n_total++;
        if (fb_catch[c] !== m_catch[c] || catch_pulse[c] !== m_pulse[c]) $display("FAIL rnd_catch k=%0d ch=%0d: got c=%b p=%b want %b/%b", k, c, fb_catch[c], catch_pulse[c], m_catch[c], m_pulse[c]);
        else n_pass++;
        n_total++;
        if (wv[c] !== m_wv[c] || ovf[c] !== m_ovf[c]) $display("FAIL rnd_wv_ovf k=%0d ch=%0d: got wv=%b o=%b want %b/%b", k, c, wv[c], ovf[c], m_wv[c], m_ovf[c]);
        else n_pass++;
        n_total++;
        if (width[c*W +: W] !== m_width[c]) $display("FAIL rnd_width k=%0d ch=%0d: got %0d want %0d", k, c, width[c*W +: W], m_width[c]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_qualify();
    test_glitch();
    test_inverted();
    test_overflow();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
